// File: rtl/snake_motion_unit.sv
// snake_motion_unit: snake body position, direction, growth and step timing with wall/body collision
// Ports: clk, rst (async active-low); gameStatus (00 RESTART, 01 START, 10 PLAY, 11 DIE),
//   restart, key1..key4_press (up/down/left/right), eat_apple in;
//   hit_wall, hit_body (sticky), step_tick, snake_len, seg_x/seg_y (packed, segment 0 is the head) out.
// Build option WRAP_AROUND_EN: head wraps at the grid edges instead of hitting the wall.
`timescale 1ns/1ps
module snake_motion_unit #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int MAX_LEN     = 16,
    parameter int INIT_LEN    = 3,
    parameter int STEP_CYCLES = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           gameStatus,
    input  logic                 restart,
    input  logic                 key1_press,
    input  logic                 key2_press,
    input  logic                 key3_press,
    input  logic                 key4_press,
    input  logic                 eat_apple,
    output logic                 hit_wall,
    output logic                 hit_body,
    output logic                 step_tick,
    output logic [4:0]           snake_len,
    output logic [MAX_LEN*6-1:0] seg_x,
    output logic [MAX_LEN*5-1:0] seg_y
);
    localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    // Encoding chosen so that dir ^ 1 is the opposite direction.
    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
    localparam logic [1:0] START = 2'b01, PLAY = 2'b10;
    logic [5:0]    sx [MAX_LEN];
    logic [4:0]    sy [MAX_LEN];
    logic [1:0]    dir, pending_dir, req;
    logic          grow_pending, latch_en, run, step, wall, body, move;
    logic [CW-1:0] step_cnt;
    logic [5:0]    nx;
    logic [4:0]    ny;
    function automatic logic [5:0] init_x(int i);
        return i < INIT_LEN ? 6'(GRID_W / 2 - i) : 6'd0;
    endfunction
    function automatic logic [4:0] init_y(int i);
        return i < INIT_LEN ? 5'(GRID_H / 2) : 5'd0;
    endfunction
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign seg_x[6*g +: 6] = sx[g];
        assign seg_y[5*g +: 5] = sy[g];
    end
    always_comb begin
        req      = key1_press ? UP : key2_press ? DOWN : key3_press ? LEFT : RIGHT;
        latch_en = (gameStatus == START || gameStatus == PLAY) &&
                   (key1_press || key2_press || key3_press || key4_press) && req != (dir ^ 2'd1);
        run      = gameStatus == PLAY && !hit_wall && !hit_body;
        step     = run && step_cnt == CW'(STEP_CYCLES - 1);
`ifdef WRAP_AROUND_EN
        nx   = pending_dir == LEFT  ? (sx[0] == 6'd0 ? 6'(GRID_W - 1) : sx[0] - 6'd1) :
               pending_dir == RIGHT ? (sx[0] == 6'(GRID_W - 1) ? 6'd0 : sx[0] + 6'd1) : sx[0];
        ny   = pending_dir == UP    ? (sy[0] == 5'd0 ? 5'(GRID_H - 1) : sy[0] - 5'd1) :
               pending_dir == DOWN  ? (sy[0] == 5'(GRID_H - 1) ? 5'd0 : sy[0] + 5'd1) : sy[0];
        wall = 1'b0;
`else
        nx   = pending_dir == LEFT ? sx[0] - 6'd1 : pending_dir == RIGHT ? sx[0] + 6'd1 : sx[0];
        ny   = pending_dir == UP   ? sy[0] - 5'd1 : pending_dir == DOWN  ? sy[0] + 5'd1 : sy[0];
        wall = (pending_dir == LEFT  && sx[0] == 6'd0) || (pending_dir == RIGHT && sx[0] == 6'(GRID_W - 1)) ||
               (pending_dir == UP    && sy[0] == 5'd0) || (pending_dir == DOWN  && sy[0] == 5'(GRID_H - 1));
`endif
        body = 1'b0;
        // The tail only blocks the head when it is about to stay put because of growth.
        for (int i = 0; i < MAX_LEN; i++)
            if ((i + 1 < int'(snake_len) || (i + 1 == int'(snake_len) && grow_pending)) && sx[i] == nx && sy[i] == ny)
                body = 1'b1;
        move = step && !wall && !body;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                sx[i] <= init_x(i);
                sy[i] <= init_y(i);
            end
            snake_len    <= 5'(INIT_LEN);
            dir          <= RIGHT;
            pending_dir  <= RIGHT;
            grow_pending <= 1'b0;
            step_cnt     <= '0;
            hit_wall     <= 1'b0;
            hit_body     <= 1'b0;
            step_tick    <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                sx[i] <= init_x(i);
                sy[i] <= init_y(i);
            end
            snake_len    <= 5'(INIT_LEN);
            dir          <= RIGHT;
            pending_dir  <= RIGHT;
            grow_pending <= 1'b0;
            step_cnt     <= '0;
            hit_wall     <= 1'b0;
            hit_body     <= 1'b0;
            step_tick    <= 1'b0;
        end else begin
            if (latch_en)
                pending_dir <= req;
            step_cnt     <= (!run || step) ? '0 : step_cnt + CW'(1);
            step_tick    <= move;
            // An eat in the step cycle survives the clear and feeds the following step.
            grow_pending <= eat_apple | (grow_pending & !move);
            if (step && wall)
                hit_wall <= 1'b1;
            if (step && !wall && body)
                hit_body <= 1'b1;
            if (move) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    sx[i] <= sx[i-1];
                    sy[i] <= sy[i-1];
                end
                sx[0] <= nx;
                sy[0] <= ny;
                dir   <= pending_dir;
                if (grow_pending && snake_len < 5'(MAX_LEN))
                    snake_len <= snake_len + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_snake_motion_unit.sv
// tb_snake_motion_unit: scoreboard bench for snake_motion_unit with a 4-cycle step period
`timescale 1ns/1ps
module tb_snake_motion_unit;
    localparam int ML = 16;
    logic clk = 0, rst = 0, restart = 0, eat = 0;
    logic k1 = 0, k2 = 0, k3 = 0, k4 = 0;
    logic [1:0] gs = 2'b10;
    logic hit_wall, hit_body, step_tick;
    logic [4:0] snake_len;
    logic [ML*6-1:0] seg_x;
    logic [ML*5-1:0] seg_y;
    snake_motion_unit #(.STEP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .gameStatus(gs), .restart(restart),
        .key1_press(k1), .key2_press(k2), .key3_press(k3), .key4_press(k4),
        .eat_apple(eat), .hit_wall(hit_wall), .hit_body(hit_body), .step_tick(step_tick),
        .snake_len(snake_len), .seg_x(seg_x), .seg_y(seg_y)
    );
    always #5 clk = ~clk;
    typedef struct {int hx; int hy; int len; int hw; int hb; int tx; int ty;} exp_t;
    exp_t q[$];
    string qn[$];
    int n_pass = 0, n_tot = 0, last_cyc = 0;
    function automatic void chk(string n, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    endfunction
    logic pw = 0, pb = 0;
    exp_t me;
    string mn;
    int mt;
    always @(negedge clk) begin
        if (step_tick || (hit_wall && !pw) || (hit_body && !pb)) begin
            if (q.size() == 0) chk("unexpected_event", 1, 0);
            else begin
                me = q.pop_front();
                mn = qn.pop_front();
                mt = int'(snake_len) - 1;
                if (mt < 0) mt = 0;
                chk({mn, "_head_x"}, int'(seg_x[5:0]), me.hx);
                chk({mn, "_head_y"}, int'(seg_y[4:0]), me.hy);
                chk({mn, "_len"}, int'(snake_len), me.len);
                chk({mn, "_hit_wall"}, int'(hit_wall), me.hw);
                chk({mn, "_hit_body"}, int'(hit_body), me.hb);
                chk({mn, "_tail_x"}, int'(seg_x[6*mt +: 6]), me.tx);
                chk({mn, "_tail_y"}, int'(seg_y[5*mt +: 5]), me.ty);
            end
        end
        pw = hit_wall;
        pb = hit_body;
    end
    task automatic wait_ev();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (step_tick || hit_wall || hit_body) begin
                last_cyc = i;
                return;
            end
        end
        last_cyc = -1;
        chk("event_timeout", 0, 1);
    endtask
    task automatic stp(string n, int key, int e, int hx, int hy, int len, int hw, int hb, int tx, int ty);
        q.push_back('{hx, hy, len, hw, hb, tx, ty});
        qn.push_back(n);
        eat = e != 0;
        case (key)
            1: k1 = 1;
            2: k2 = 1;
            3: k3 = 1;
            4: k4 = 1;
            34: begin k3 = 1; k4 = 1; end
            12: begin k1 = 1; @(negedge clk); k1 = 0; eat = 0; k2 = 1; end
            default: ;
        endcase
        if (e != 0 || key != 0) begin
            @(negedge clk);
            {k1, k2, k3, k4, eat} = '0;
        end
        wait_ev();
    endtask
    task automatic chk_init(string p);
        chk({p, "_len"}, int'(snake_len), 3);
        chk({p, "_x0"}, int'(seg_x[5:0]), 20);
        chk({p, "_y0"}, int'(seg_y[4:0]), 15);
        chk({p, "_x1"}, int'(seg_x[11:6]), 19);
        chk({p, "_y1"}, int'(seg_y[9:5]), 15);
        chk({p, "_x2"}, int'(seg_x[17:12]), 18);
        chk({p, "_x3"}, int'(seg_x[23:18]), 0);
        chk({p, "_y3"}, int'(seg_y[19:15]), 0);
        chk({p, "_flags"}, int'({hit_wall, hit_body}), 0);
        chk({p, "_tick"}, int'(step_tick), 0);
    endtask
    task automatic do_restart(logic [1:0] st, int n);
        gs = st;
        restart = 1;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk_init("reset");
        rst = 1;
        stp("A1", 0, 0, 21, 15, 3, 0, 0, 19, 15);
        chk("period_first", last_cyc, 4);
        stp("A2", 0, 0, 22, 15, 3, 0, 0, 20, 15);
        chk("period", last_cyc, 4);
        stp("A3_reverse_ignored", 3, 0, 23, 15, 3, 0, 0, 21, 15);
        stp("A4_up", 1, 0, 23, 14, 3, 0, 0, 22, 15);
        stp("A5_prio", 34, 0, 22, 14, 3, 0, 0, 23, 15);
        stp("A6_last_wins", 12, 0, 22, 15, 3, 0, 0, 23, 14);
        stp("A7_grow", 0, 1, 22, 16, 4, 0, 0, 23, 14);
        stp("A8", 0, 0, 22, 17, 4, 0, 0, 22, 14);
        stp("A9_grow", 0, 1, 22, 18, 5, 0, 0, 22, 14);
        stp("A10", 3, 0, 21, 18, 5, 0, 0, 22, 15);
        stp("A11", 1, 0, 21, 17, 5, 0, 0, 22, 16);
        stp("A12_body_hit", 4, 0, 21, 17, 5, 0, 1, 22, 16);
        repeat (10) @(negedge clk);
        chk("body_frozen_x", int'(seg_x[5:0]), 21);
        chk("body_frozen_y", int'(seg_y[4:0]), 17);
        chk("body_flag_held", int'(hit_body), 1);
        do_restart(2'b11, 7);
        chk_init("restart");
        restart = 0;
        gs = 2'b10;
        stp("B1_grow", 0, 1, 21, 15, 4, 0, 0, 18, 15);
        stp("B2", 1, 0, 21, 14, 4, 0, 0, 19, 15);
        stp("B3", 3, 0, 20, 14, 4, 0, 0, 20, 15);
        stp("B4_into_vacating_tail", 2, 0, 20, 15, 4, 0, 0, 21, 15);
        stp("B5_into_growing_tail", 4, 1, 20, 15, 4, 0, 1, 21, 15);
        do_restart(2'b01, 2);
        restart = 0;
        gs = 2'b10;
        stp("C1", 0, 0, 21, 15, 3, 0, 0, 19, 15);
        @(negedge clk);
        #2 rst = 0;
        #1 chk_init("async_rst");
        @(negedge clk);
        rst = 1;
        stp("D1", 0, 0, 21, 15, 3, 0, 0, 19, 15);
        q.push_back('{22, 15, 3, 0, 0, 20, 15});
        qn.push_back("D2_eat_in_step_cycle");
        repeat (3) @(negedge clk);
        eat = 1;
        wait_ev();
        eat = 0;
        stp("D3_late_grow", 0, 0, 23, 15, 4, 0, 0, 20, 15);
        for (int k = 4; k <= 19; k++)
            stp($sformatf("D%0d", k), 0, 0, 20 + k, 15, 4, 0, 0, 17 + k, 15);
`ifdef WRAP_AROUND_EN
        stp("D20_wrap", 0, 0, 0, 15, 4, 0, 0, 37, 15);
        gs = 2'b11;
        chk("wrap_no_wall", int'(hit_wall), 0);
`else
        stp("D20_wall", 0, 0, 39, 15, 4, 1, 0, 36, 15);
        repeat (10) @(negedge clk);
        chk("wall_frozen_x", int'(seg_x[5:0]), 39);
        chk("wall_flag_held", int'(hit_wall), 1);
`endif
        do_restart(2'b01, 2);
        restart = 0;
        gs = 2'b10;
        for (int k = 1; k <= 15; k++)
            stp($sformatf("E%0d", k), 0, 1, 20 + k, 15, k <= 13 ? 3 + k : 16, 0, 0, k <= 13 ? 18 : 5 + k, 15);
        stp("E16", 0, 0, 36, 15, 16, 0, 0, 21, 15);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
